// File: rtl/demux_conductual_1x4_4bits_pkg.sv
// Shared constants for the 1x4 round-robin demux and its lane FIFOs.
package demux_conductual_1x4_4bits_pkg;
  localparam int   LANES        = 4;
  localparam int   SEL_W        = 2;
  localparam logic DATA_RST_BIT = 1'b0;
endpackage

// File: rtl/demux_conductual_1x4_4bits_fifo_lane.sv
// One output lane: a small FIFO whose head word is registered, so a word
// written into an empty lane reaches the head one edge after it is stored.
module fifo_lane_4bits
  import demux_conductual_1x4_4bits_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clok,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             push_drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_vis, count_nxt;
  logic             head_vld;
  logic             pop_ok, push_ok;

  // Pop frees a slot before the push lands, so push+pop on a full lane fits.
  // count_vis excludes this edge's push, which delays the head by one edge.
  always_comb begin
    pop_ok     = pop & head_vld;
    push_ok    = push & (~full | pop_ok);
    push_drop  = push & ~push_ok;
    rd_ptr_nxt = rd_ptr + PTR_W'(pop_ok);
    count_vis  = count - CNT_W'(pop_ok);
    count_nxt  = count_vis + CNT_W'(push_ok);
  end

  always_ff @(posedge clok) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      head_vld <= 1'b0;
      head     <= {WIDTH{DATA_RST_BIT}};
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      head_vld <= (count_vis != '0);
      head     <= mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clok) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  assign empty = ~head_vld;
endmodule

// File: rtl/demux_conductual_1x4_4bits.sv
// Round-robin 1x4 demux: routes each valid upstream word to lanes 0..3 in turn,
// flags frame completion after lane 3 and records per-lane drops.
module demux_conductual_1x4_4bits
  import demux_conductual_1x4_4bits_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clok,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic [LANES-1:0] pop,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic [LANES-1:0] valid_out,
  output logic [LANES-1:0] full,
  output logic             frame_done,
  output logic [LANES-1:0] overflow
);
  logic [SEL_W-1:0] sel;
  logic [LANES-1:0] push, drop, empty;
  logic [WIDTH-1:0] head [LANES];

  always_comb begin
    push = '0;
    for (int i = 0; i < LANES; i++) begin
      push[i] = valid_in && (sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fifo_lane_4bits #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_lane (
      .clok      (clok),
      .reset     (reset),
      .push      (push[g]),
      .pop       (pop[g]),
      .data_in   (data_in),
      .head      (head[g]),
      .empty     (empty[g]),
      .full      (full[g]),
      .push_drop (drop[g])
    );
  end

  // sel advances on every valid word, dropped or not, to stay aligned upstream.
  always_ff @(posedge clok) begin
    if (reset) begin
      sel        <= '0;
      frame_done <= 1'b0;
      overflow   <= '0;
    end else begin
      if (valid_in) sel <= sel + SEL_W'(1);
      frame_done <= valid_in && (sel == SEL_W'(LANES - 1));
      overflow   <= overflow | drop;
    end
  end

  assign valid_out = ~empty;
  assign data_out0 = head[0];
  assign data_out1 = head[1];
  assign data_out2 = head[2];
  assign data_out3 = head[3];
endmodule

// File: tb/tb_demux_conductual_1x4_4bits.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a queue-based lane model.
module tb_demux_conductual_1x4_4bits;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic       clok = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       valid_in;
  logic [3:0] pop;
  logic [3:0] data_out0, data_out1, data_out2, data_out3;
  logic [3:0] valid_out, full, overflow;
  logic       frame_done;

  always #5 clok = ~clok;

  demux_conductual_1x4_4bits #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clok       (clok),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .pop        (pop),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out  (valid_out),
    .full       (full),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dout(input int i);
    case (i)
      0: return data_out0;
      1: return data_out1;
      2: return data_out2;
      default: return data_out3;
    endcase
  endfunction

  // Reference model: each lane is a queue of (word, edge written). A word is
  // visible at the head once at least one full edge has passed since its write.
  typedef struct {
    logic [3:0] w;
    int         e;
  } ent_t;

  ent_t       mq [4][$];
  int         edge_n = 0;
  int         m_sel  = 0;
  logic [3:0] m_ov   = '0;
  logic       m_fd   = 1'b0;
  logic [3:0] m_vis  = '0;

  task automatic model_edge(input logic r, input logic vin, input logic [3:0] d, input logic [3:0] p);
    ent_t en;
    edge_n++;
    if (r) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_sel = 0;
      m_ov  = '0;
      m_fd  = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (p[i] && m_vis[i]) void'(mq[i].pop_front());
      m_fd = vin && (m_sel == 3);
      if (vin) begin
        if (mq[m_sel].size() < DEPTH) begin
          en.w = d;
          en.e = edge_n;
          mq[m_sel].push_back(en);
        end else begin
          m_ov[m_sel] = 1'b1;
        end
        m_sel = (m_sel + 1) % 4;
      end
    end
    for (int i = 0; i < 4; i++)
      m_vis[i] = (mq[i].size() > 0) && (mq[i][0].e < edge_n);
  endtask

  task automatic step(input logic r, input logic vin, input logic [3:0] d, input logic [3:0] p);
    reset    = r;
    valid_in = vin;
    data_in  = d;
    pop      = p;
    @(posedge clok);
    model_edge(r, vin, d, p);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] m_full;
    for (int i = 0; i < 4; i++) m_full[i] = (mq[i].size() == DEPTH);
    check({tag, " valid_out"}, valid_out, m_vis);
    check({tag, " full"}, full, m_full);
    check({tag, " frame_done"}, frame_done, m_fd);
    check({tag, " overflow"}, overflow, m_ov);
    for (int i = 0; i < 4; i++)
      if (m_vis[i]) check($sformatf("%s data_out%0d", tag, i), dout(i), mq[i][0].w);
  endtask

  typedef struct {
    logic        vin;
    logic [3:0]  d;
    logic [3:0]  p;
    logic [3:0]  vo;
    logic [3:0]  fl;
    logic        fd;
    logic [3:0]  ov;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic       r_in, v_in;
    logic [3:0] d_in, p_in;

    tbl[0]  = '{1'b1, 4'h1, 4'h0, 4'b0000, 4'h0, 1'b0, 4'h0, 16'h0000};
    tbl[1]  = '{1'b1, 4'h2, 4'h0, 4'b0001, 4'h0, 1'b0, 4'h0, 16'h0001};
    tbl[2]  = '{1'b1, 4'h3, 4'h0, 4'b0011, 4'h0, 1'b0, 4'h0, 16'h0021};
    tbl[3]  = '{1'b1, 4'h4, 4'h0, 4'b0111, 4'h0, 1'b1, 4'h0, 16'h0321};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[5]  = '{1'b1, 4'hA, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[7]  = '{1'b1, 4'hB, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[11] = '{1'b1, 4'hC, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4321};
    tbl[13] = '{1'b0, 4'h0, 4'b0111, 4'b1111, 4'h0, 1'b0, 4'h0, 16'h4CBA};
    tbl[14] = '{1'b0, 4'h0, 4'b1111, 4'b0000, 4'h0, 1'b0, 4'h0, 16'h0000};

    // Reset state
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    check("reset valid_out", valid_out, 4'h0);
    check("reset full", full, 4'h0);
    check("reset frame_done", frame_done, 1'b0);
    check("reset overflow", overflow, 4'h0);
    check("reset data_out", {data_out3, data_out2, data_out1, data_out0}, 16'h0000);

    // Directed table: first frame, idle gaps, pops
    for (int k = 0; k < 15; k++) begin
      step(1'b0, tbl[k].vin, tbl[k].d, tbl[k].p);
      check($sformatf("tbl%0d valid_out", k), valid_out, tbl[k].vo);
      check($sformatf("tbl%0d full", k), full, tbl[k].fl);
      check($sformatf("tbl%0d frame_done", k), frame_done, tbl[k].fd);
      check($sformatf("tbl%0d overflow", k), overflow, tbl[k].ov);
      for (int i = 0; i < 4; i++)
        if (tbl[k].vo[i]) check($sformatf("tbl%0d data_out%0d", k, i), dout(i), tbl[k].dat[4*i +: 4]);
    end

    // Pop on an empty lane is ignored
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 4'h1, 4'h0);
    step(1'b0, 1'b1, 4'h2, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'b0100);
    check("empty pop valid_out", valid_out, 4'b0011);
    step(1'b0, 1'b1, 4'h9, 4'h0);
    check("lane2 latency valid_out", valid_out, 4'b0011);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    check("lane2 write valid_out", valid_out, 4'b0111);
    check("lane2 write data_out2", data_out2, 4'h9);

    // Full lane with simultaneous pop and write
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 4'(k), 4'h0);
    step(1'b0, 1'b1, 4'hE, 4'b0001);
    check("push+pop full", full, 4'b1111);
    check("push+pop overflow", overflow, 4'h0);
    check("push+pop data_out0", data_out0, 4'h4);
    step(1'b0, 1'b0, 4'h0, 4'b0001);
    check("pop1 full", full, 4'b1110);
    check("pop1 data_out0", data_out0, 4'h8);
    step(1'b0, 1'b0, 4'h0, 4'b0001);
    check("pop2 data_out0", data_out0, 4'hC);
    step(1'b0, 1'b0, 4'h0, 4'b0001);
    check("pop3 data_out0", data_out0, 4'hE);

    // Overflow on full lanes, then reset mid-frame
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 4'(k), 4'h0);
    check("fill full", full, 4'b1111);
    check("fill overflow", overflow, 4'h0);
    step(1'b0, 1'b1, 4'hF, 4'h0);
    check("drop0 overflow", overflow, 4'b0001);
    check("drop0 data_out0", data_out0, 4'h0);
    step(1'b0, 1'b1, 4'h5, 4'h0);
    check("drop1 overflow", overflow, 4'b0011);
    check("drop1 data_out1", data_out1, 4'h1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'h6, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    check("midreset valid_out", valid_out, 4'h0);
    check("midreset full", full, 4'h0);
    check("midreset overflow", overflow, 4'h0);
    check("midreset frame_done", frame_done, 1'b0);
    step(1'b0, 1'b1, 4'h7, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    check("after reset valid_out", valid_out, 4'b0001);
    check("after reset data_out0", data_out0, 4'h7);

    // Randomized run against the model
    step(1'b1, 1'b0, 4'h0, 4'h0);
    check_model("rnd reset");
    for (int k = 0; k < 1500; k++) begin
      r_in = ($urandom_range(0, 199) == 0);
      v_in = ($urandom_range(0, 3) != 0);
      d_in = 4'($urandom);
      if ((k % 300) < 150) p_in = 4'($urandom & $urandom & $urandom);
      else                 p_in = 4'($urandom);
      step(r_in, v_in, d_in, p_in);
      check_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_conductual_1x4_4bits.md
Name: demux_conductual_1x4_4bits

Overview:
- Downstream stage of the 4x1 4-bit valid-tagged mux. Consumes its serialized output stream (data + valid) and redistributes words round-robin to four output lanes, lane order 0,1,2,3.
- Each lane has a small FIFO so downstream consumers can drain at their own rate.
- Reports frame completion and per-lane overflow.

Parameters:
- WIDTH, 4, data bus width in bits.
- DEPTH, 4, entries per lane FIFO (power of two, >=2).

Ports:
- clok  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word from upstream mux output.
- valid_in  input  1  data_in qualifier; one word accepted per cycle when high.
- pop  input  4  pop[i] requests removal of lane i head word.
- data_out0..data_out3  output  WIDTH each  head word of lane i FIFO (registered).
- valid_out  output  4  valid_out[i]=1 when lane i FIFO non-empty; data_outi meaningful.
- full  output  4  full[i]=1 when lane i holds DEPTH words.
- frame_done  output  1  one-cycle pulse after a word is routed to lane 3.
- overflow  output  4  sticky; overflow[i] set when a word targeted at full lane i is dropped.

Behaviour:
- Reset: all FIFO pointers/counts 0, lane selector sel=0, data_out* = 0, valid_out=0, full=0, frame_done=0, overflow=0. A reset asserted mid-operation discards all stored words and returns sel to 0 on the next edge.
- Routing: sel is a 2-bit counter. On a cycle with valid_in=1, the word is written to lane sel and sel increments mod 4 (3->0). On valid_in=0, sel holds.
- Write latency: a word accepted at edge N is visible on data_outi with valid_out[i]=1 after edge N+1 if lane i was empty. One cycle of write-to-head latency.
- Pop: pop[i] with valid_out[i]=1 removes the head at the edge. The next word, or empty, appears after that edge. pop[i] with valid_out[i]=0 is ignored; the count does not underflow.
- Simultaneous write and pop on the same lane: both take effect, the count is unchanged, and the write is accepted even when full=1.
- Full lane, write without pop: the word is dropped, overflow[i] is set and stays set until reset, and sel still advances so lane order stays aligned with the upstream sequence.
- Pointers wrap mod DEPTH. Count range is 0..DEPTH. full[i] = (count==DEPTH), registered together with the pointers.
- frame_done: asserted for exactly one cycle, on the cycle after a valid_in word is routed with sel=3. This holds whether or not the word was dropped.
- Lanes are independent. Pops on different lanes in the same cycle are all honoured.
- Upstream mux selection order 0..3 matches sel. No backpressure exists toward upstream; data is lost only via overflow.

Decomposition:
- Shared package/include holds: lane count constant (4), selector width (2), and the reset value of the data word (all zeros).
- One natural sub-module: fifo_lane_4bits (parameterized WIDTH/DEPTH; push, pop, data_in, head, empty, full, push_drop). Instantiate it four times. The top level keeps only the sel counter, write decode, frame_done and overflow registers.

Test Plan:
- Reset, then valid_in=1 for 4 cycles with data 0x1,0x2,0x3,0x4 and no pops -> after the last write edge plus 1: data_out0..3 = 1,2,3,4; valid_out=4'b1111; frame_done pulses once, one cycle after the 0x4 write; sel back to 0.
- valid_in gaps: words A,(idle),B,(idle 3 cycles),C -> A in lane0, B in lane1, C in lane2; sel does not advance on idle cycles.
- Fill lane0 with DEPTH=4 words (16 writes total, no pops) -> full=4'b1111; a 17th write (0xF) is dropped, overflow[0]=1, and the other overflow bits stay 0. The next write goes to lane1 and is dropped as well, setting overflow[1]=1.
- Lane0 full, with pop[0]=1 on the same cycle as a write to lane0 -> count stays 4, overflow[0] stays 0, head advances to the second word, and the new word becomes the tail.
- pop[2]=1 while lane2 is empty -> no change, valid_out[2]=0, no pointer corruption. A subsequent write of 0x9 appears on data_out2 one cycle later.
- Reset asserted after 6 writes, mid-frame -> next edge: valid_out=0, full=0, overflow=0, sel=0. The next write 0x7 lands in lane0.
